// File: rtl/dbg_arbiter_if.sv
// Signal bundle between the two debug front-ends, the arbiter and the debug module.
// slave is the arbiter's view; master is the front-end / debug-module side.
interface dbg_arbiter_if;
    logic [1:0]  req_i;
    logic [7:0]  cmd0_i;
    logic [7:0]  cmd1_i;
    logic [31:0] addr0_i;
    logic [31:0] addr1_i;
    logic [31:0] data0_i;
    logic [31:0] data1_i;
    logic [1:0]  gnt_o;
    logic [1:0]  done_o;
    logic [1:0]  err_o;
    logic [31:0] rdata_o;
    logic        busy_o;
    logic [7:0]  dbg_cmd_o;
    logic [31:0] dbg_addr_o;
    logic [31:0] dbg_data_o;
    logic [31:0] dbg_rdata_i;
    logic        dbg_ready_i;

    modport slave (
        input  req_i, cmd0_i, cmd1_i, addr0_i, addr1_i, data0_i, data1_i,
        input  dbg_rdata_i, dbg_ready_i,
        output gnt_o, done_o, err_o, rdata_o, busy_o,
        output dbg_cmd_o, dbg_addr_o, dbg_data_o
    );

    modport master (
        output req_i, cmd0_i, cmd1_i, addr0_i, addr1_i, data0_i, data1_i,
        output dbg_rdata_i, dbg_ready_i,
        input  gnt_o, done_o, err_o, rdata_o, busy_o,
        input  dbg_cmd_o, dbg_addr_o, dbg_data_o
    );
endinterface

// File: rtl/dbg_arbiter.sv
// Round-robin arbiter sharing the debug module command port between the UART tap
// (port 0) and the JTAG tap (port 1), with a ready-timeout watchdog.
//
// state | meaning
// IDLE  | no owner; pick a requester, latch its command
// EXEC  | command driven to the debug module, waiting for ready or timeout
// RESP  | one-cycle done/err pulse with read data to the owner
module dbg_arbiter #(
    parameter int TIMEOUT = 1024
) (
    input  logic         clk,
    input  logic         rst_i,
    dbg_arbiter_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

    localparam int CW = (TIMEOUT > 0) ? (($clog2(TIMEOUT + 1) > 0) ? $clog2(TIMEOUT + 1) : 1) : 1;
    localparam logic [CW-1:0] CNT_TC = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    state_t        state_q, state_d;
    logic          idx_q, idx_d;
    logic          last_q, last_d;
    logic [1:0]    mask_q, mask_d;
    logic [7:0]    cmd_q, cmd_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   data_q, data_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [1:0]    eff_req;
    logic          sel;
    logic [7:0]    sel_cmd;
    logic [1:0]    owner;

    always_ff @(posedge clk) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            idx_q   <= 1'b0;
            last_q  <= 1'b1;
            mask_q  <= 2'b00;
            cmd_q   <= 8'h00;
            addr_q  <= 32'h0;
            data_q  <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            mask_q  <= mask_d;
            cmd_q   <= cmd_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        last_d  = last_q;
        mask_d  = 2'b00;
        cmd_d   = cmd_q;
        addr_d  = addr_q;
        data_d  = data_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        eff_req = bus.req_i & ~mask_q;
        sel     = 1'b0;
        sel_cmd = 8'h00;

        case (state_q)
            S_IDLE: begin
                if (eff_req != 2'b00) begin
                    // on a tie, the port that was not served last wins
                    sel     = (eff_req == 2'b11) ? ~last_q : eff_req[1];
                    sel_cmd = sel ? bus.cmd1_i : bus.cmd0_i;
                    idx_d   = sel;
                    last_d  = sel;
                    cmd_d   = sel_cmd;
                    addr_d  = sel ? bus.addr1_i : bus.addr0_i;
                    data_d  = sel ? bus.data1_i : bus.data0_i;
                    if (sel_cmd != 8'h00) begin
                        state_d = S_EXEC;
                        cnt_d   = '0;
                    end else begin
                        state_d = S_RESP;
                        rdata_d = 32'h0;
                        err_d   = 1'b0;
                    end
                end
            end
            S_EXEC: begin
                if (cnt_q != '1) cnt_d = cnt_q + CW'(1);
                if (bus.dbg_ready_i) begin
                    state_d = S_RESP;
                    rdata_d = bus.dbg_rdata_i;
                    err_d   = 1'b0;
                end else if ((TIMEOUT != 0) && (cnt_q == CNT_TC)) begin
                    state_d = S_RESP;
                    rdata_d = 32'h0;
                    err_d   = 1'b1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
                // the served port still holds req for one cycle after done
                mask_d  = idx_q ? 2'b10 : 2'b01;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign owner = idx_q ? 2'b10 : 2'b01;

    assign bus.gnt_o      = (state_q != S_IDLE) ? owner : 2'b00;
    assign bus.done_o     = (state_q == S_RESP) ? owner : 2'b00;
    assign bus.err_o      = ((state_q == S_RESP) && err_q) ? owner : 2'b00;
    assign bus.rdata_o    = (state_q == S_RESP) ? rdata_q : 32'h0;
    assign bus.busy_o     = (state_q != S_IDLE);
    assign bus.dbg_cmd_o  = (state_q == S_EXEC) ? cmd_q : 8'h00;
    assign bus.dbg_addr_o = addr_q;
    assign bus.dbg_data_o = data_q;
endmodule

// File: tb/tb_dbg_arbiter.sv
// Scoreboard bench for dbg_arbiter: expected completions are queued at issue and
// popped by a monitor whenever the arbiter pulses done.
module tb_dbg_arbiter;
    logic clk;
    logic rst_i;

    dbg_arbiter_if bus();

    dbg_arbiter #(.TIMEOUT(8)) dut (
        .clk   (clk),
        .rst_i (rst_i),
        .bus   (bus)
    );

    typedef struct packed {
        logic [1:0]  done;
        logic [1:0]  err;
        logic [31:0] rdata;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   lat      = 1;
    int   exec_cnt = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rdata_fn(input logic [31:0] a);
        return a ^ 32'hDEAD_AEEF;
    endfunction

    function automatic void push_exp(input logic [1:0] d, input logic [1:0] e, input logic [31:0] r);
        exp_q.push_back({d, e, r});
    endfunction

    // debug module model: ready on the lat-th EXEC cycle, never if lat is 0
    always @(negedge clk) begin
        if (bus.dbg_cmd_o != 8'h00) begin
            exec_cnt++;
            bus.dbg_ready_i = (exec_cnt == lat);
            bus.dbg_rdata_i = rdata_fn(bus.dbg_addr_o);
        end else begin
            exec_cnt = 0;
            bus.dbg_ready_i = 1'b0;
            bus.dbg_rdata_i = 32'h0BAD_F00D;
        end
    end

    always @(negedge clk) begin
        if (!rst_i && bus.done_o != 2'b00) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_done", 32'(bus.done_o), 32'h0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sb_done", 32'(bus.done_o), 32'(e.done));
                check("sb_err", 32'(bus.err_o), 32'(e.err));
                check("sb_rdata", bus.rdata_o, e.rdata);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_exec(input string tag);
        int n = 0;
        do begin
            tick();
            n++;
        end while (bus.dbg_cmd_o == 8'h00 && n < 12);
        check(tag, 32'(bus.dbg_cmd_o != 8'h00), 32'h1);
    endtask

    task automatic wait_resp(input string tag);
        int n = 0;
        do begin
            tick();
            n++;
        end while (bus.done_o == 2'b00 && n < 20);
        check(tag, 32'(bus.done_o != 2'b00), 32'h1);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_gnt"},   32'(bus.gnt_o), 32'h0);
        check({tag, "_done"},  32'(bus.done_o), 32'h0);
        check({tag, "_err"},   32'(bus.err_o), 32'h0);
        check({tag, "_busy"},  32'(bus.busy_o), 32'h0);
        check({tag, "_cmd"},   32'(bus.dbg_cmd_o), 32'h0);
        check({tag, "_rdata"}, bus.rdata_o, 32'h0);
        check({tag, "_addr"},  bus.dbg_addr_o, 32'h0);
        check({tag, "_data"},  bus.dbg_data_o, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b1;
        bus.req_i = 2'b00;
        bus.cmd0_i = 8'h00;  bus.cmd1_i = 8'h00;
        bus.addr0_i = 32'h0; bus.addr1_i = 32'h0;
        bus.data0_i = 32'h0; bus.data1_i = 32'h0;
        bus.dbg_ready_i = 1'b0;
        bus.dbg_rdata_i = 32'h0;
        repeat (3) tick();
        check_quiet("reset");

        // single memory read, ready on the 3rd EXEC cycle
        rst_i = 1'b0;
        lat = 3;
        bus.cmd0_i = 8'h80; bus.addr0_i = 32'h0000_1000; bus.data0_i = 32'h5555_0000;
        bus.req_i = 2'b01;
        push_exp(2'b01, 2'b00, 32'hDEAD_BEEF);
        tick();
        check("rd_gnt", 32'(bus.gnt_o), 32'h1);
        check("rd_addr", bus.dbg_addr_o, 32'h0000_1000);
        for (int k = 1; k <= 3; k++) begin
            if (k > 1) tick();
            check("rd_cmd_exec", 32'(bus.dbg_cmd_o), 32'h80);
            check("rd_no_done", 32'(bus.done_o), 32'h0);
        end
        tick();
        check("rd_resp_done", 32'(bus.done_o), 32'h1);
        check("rd_resp_cmd0", 32'(bus.dbg_cmd_o), 32'h0);
        check("rd_resp_gnt", 32'(bus.gnt_o), 32'h1);
        bus.req_i = 2'b00;
        tick();
        check("rd_idle_gnt", 32'(bus.gnt_o), 32'h0);
        check("rd_idle_busy", 32'(bus.busy_o), 32'h0);
        tick();

        // round robin with both ports requesting continuously
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        lat = 1;
        bus.cmd0_i = 8'h81; bus.addr0_i = 32'h0000_2000;
        bus.cmd1_i = 8'h82; bus.addr1_i = 32'h0000_3000;
        for (int i = 0; i < 4; i++)
            push_exp((i % 2 == 0) ? 2'b01 : 2'b10, 2'b00,
                     rdata_fn((i % 2 == 0) ? 32'h0000_2000 : 32'h0000_3000));
        bus.req_i = 2'b11;
        for (int i = 0; i < 4; i++) begin
            wait_exec("rr_wait_exec");
            check("rr_gnt", 32'(bus.gnt_o), (i % 2 == 0) ? 32'h1 : 32'h2);
            check("rr_cmd", 32'(bus.dbg_cmd_o), (i % 2 == 0) ? 32'h81 : 32'h82);
            if (i == 3) bus.req_i = 2'b10;
            wait_resp("rr_wait_resp");
            if (i == 3) bus.req_i = 2'b00;
        end
        repeat (2) tick();

        // port 0 keeps requesting after done: masked for one cycle, then re-granted
        lat = 1;
        bus.cmd0_i = 8'h83; bus.addr0_i = 32'h0000_4000;
        push_exp(2'b01, 2'b00, rdata_fn(32'h0000_4000));
        push_exp(2'b01, 2'b00, rdata_fn(32'h0000_4000));
        bus.req_i = 2'b01;
        wait_exec("mask_wait_exec");
        check("mask_first_gnt", 32'(bus.gnt_o), 32'h1);
        wait_resp("mask_wait_resp");
        tick();
        check("mask_idle_busy", 32'(bus.busy_o), 32'h0);
        tick();
        check("mask_no_regrant", 32'(bus.gnt_o), 32'h0);
        tick();
        check("mask_fresh_grant", 32'(bus.gnt_o), 32'h1);
        wait_resp("mask_wait_resp2");
        bus.req_i = 2'b00;
        repeat (2) tick();

        // watchdog: no ready, done+err exactly TIMEOUT cycles after EXEC entry
        lat = 0;
        bus.cmd1_i = 8'hC0; bus.addr1_i = 32'h0000_5000; bus.data1_i = 32'h1234_ABCD;
        push_exp(2'b10, 2'b10, 32'h0);
        bus.req_i = 2'b10;
        tick();
        check("to_gnt", 32'(bus.gnt_o), 32'h2);
        check("to_cmd", 32'(bus.dbg_cmd_o), 32'hC0);
        check("to_data", bus.dbg_data_o, 32'h1234_ABCD);
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k == 2) begin
                bus.cmd1_i = 8'h11; bus.addr1_i = 32'h0; bus.data1_i = 32'h0;
            end
            check("to_no_early_done", 32'(bus.done_o), 32'h0);
            check("to_cmd_held", 32'(bus.dbg_cmd_o), 32'hC0);
            check("to_addr_held", bus.dbg_addr_o, 32'h0000_5000);
        end
        tick();
        check("to_done", 32'(bus.done_o), 32'h2);
        check("to_err", 32'(bus.err_o), 32'h2);
        check("to_cmd_cleared", 32'(bus.dbg_cmd_o), 32'h0);
        bus.req_i = 2'b00;
        repeat (2) tick();

        // zero command completes without touching the debug module
        lat = 1;
        bus.cmd1_i = 8'h00; bus.addr1_i = 32'h0000_6000;
        push_exp(2'b10, 2'b00, 32'h0);
        bus.req_i = 2'b10;
        tick();
        check("nop_done", 32'(bus.done_o), 32'h2);
        check("nop_cmd", 32'(bus.dbg_cmd_o), 32'h0);
        check("nop_gnt", 32'(bus.gnt_o), 32'h2);
        bus.req_i = 2'b00;
        repeat (2) tick();

        // reset in the middle of EXEC, then a tie goes to port 0
        lat = 0;
        bus.cmd0_i = 8'h80; bus.addr0_i = 32'h0000_7000;
        bus.req_i = 2'b01;
        tick();
        check("rst_exec_cmd", 32'(bus.dbg_cmd_o), 32'h80);
        tick();
        rst_i = 1'b1;
        tick();
        check_quiet("rst_mid");
        rst_i = 1'b0;
        lat = 1;
        bus.cmd0_i = 8'h81; bus.addr0_i = 32'h0000_7000;
        bus.cmd1_i = 8'h82; bus.addr1_i = 32'h0000_8000;
        push_exp(2'b01, 2'b00, rdata_fn(32'h0000_7000));
        bus.req_i = 2'b11;
        tick();
        check("rst_tie_p0", 32'(bus.gnt_o), 32'h1);
        bus.req_i = 2'b01;
        wait_resp("rst_wait_resp");
        bus.req_i = 2'b00;
        repeat (3) tick();

        check("sb_drained", 32'(exp_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
